// File: rtl/sequential_unary_reduce_pkg.sv
// Shared types and helpers for the multi-cycle unary reduction engine.
// Operation encoding, FSM states and the accumulator seed live here.
package sequential_unary_reduce_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // AND starts from the identity 1; OR/XOR/XNOR start from 0
    function automatic logic init_acc(input op_e op_i);
        logic seed_s;
        case (op_i)
            OP_AND:  seed_s = 1'b1;
            OP_OR:   seed_s = 1'b0;
            OP_XOR:  seed_s = 1'b0;
            OP_XNOR: seed_s = 1'b0;
            default: seed_s = 1'b0;
        endcase
        return seed_s;
    endfunction

endpackage

// File: rtl/sequential_unary_reduce_fold.sv
// Combinational fold of one W-bit chunk into the running accumulator.
// Flags early termination when the AND/OR result can no longer change.
module unary_chunk_fold
    import sequential_unary_reduce_pkg::*;
#(
    parameter int W = 8
) (
    input  op_e          op,
    input  logic [W-1:0] chunk,
    input  logic         acc,
    output logic         acc_next,
    output logic         early
);

    // Select the reduction for the active op and derive the early-exit flag
    always_comb begin
        acc_next = acc;
        early    = 1'b0;
        case (op)
            OP_AND: begin
                acc_next = acc & (&chunk);
                early    = ~acc_next;
            end
            OP_OR: begin
                acc_next = acc | (|chunk);
                early    = acc_next;
            end
            OP_XOR: begin
                acc_next = acc ^ (^chunk);
                early    = 1'b0;
            end
            OP_XNOR: begin
                acc_next = acc ^ (^chunk);
                early    = 1'b0;
            end
            default: begin
                acc_next = acc;
                early    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sequential_unary_reduce.sv
// Multi-cycle AND/OR/XOR/XNOR reduction of an N-bit operand, W bits per cycle,
// with valid/ready handshakes on both the operand and the result side.
module sequential_unary_reduce
    import sequential_unary_reduce_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 c,
    output logic [$clog2(N/W):0] chunks
);

    localparam int NCHUNK = N / W;
    localparam int CW     = $clog2(NCHUNK) + 1;

    generate
        if ((N % W) != 0 || W < 1 || W > N) begin : g_bad_width
            $error("sequential_unary_reduce: N must be a positive multiple of W");
        end
    endgenerate

    state_e        state_r;
    state_e        state_s;
    logic [N-1:0]  sr_r;
    op_e           op_r;
    logic          acc_r;
    logic [CW-1:0] cnt_r;
    logic          c_r;
    logic [CW-1:0] chunks_r;
    logic          acc_next_s;
    logic          early_s;
    logic          last_s;
    logic          accept_s;
    logic          finish_s;

    unary_chunk_fold #(.W(W)) u_fold (
        .op       (op_r),
        .chunk    (sr_r[W-1:0]),
        .acc      (acc_r),
        .acc_next (acc_next_s),
        .early    (early_s)
    );

    assign in_ready  = (state_r == S_IDLE) && !rst;
    assign out_valid = (state_r == S_DONE);
    assign c         = c_r;
    assign chunks    = chunks_r;
    assign accept_s  = in_valid && in_ready;
    assign last_s    = ((cnt_r + CW'(1)) == CW'(NCHUNK));
    assign finish_s  = last_s || early_s;

    // Next-state logic for the accept / fold / hold-result sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_BUSY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (finish_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, per-cycle fold and result latching on the final fold
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r     <= '0;
            op_r     <= OP_AND;
            acc_r    <= 1'b0;
            cnt_r    <= '0;
            c_r      <= 1'b0;
            chunks_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        sr_r  <= a;
                        op_r  <= op_e'(op);
                        acc_r <= init_acc(op_e'(op));
                        cnt_r <= '0;
                    end
                end
                S_BUSY: begin
                    acc_r <= acc_next_s;
                    sr_r  <= sr_r >> W;
                    cnt_r <= cnt_r + CW'(1);
                    if (finish_s) begin
                        c_r      <= (op_r == OP_XNOR) ? ~acc_next_s : acc_next_s;
                        chunks_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    sr_r <= sr_r;
                end
            endcase
        end
    end

endmodule
